// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for a single iterative AES-128 round datapath.
// Accepts a plaintext block, issues rounds 0..NUM_RND with round-key indices,
// feeds the registered round result back, and holds the ciphertext until taken.
// Optional feature macro: AES_RND_CTRL_ABORT_EN adds i_abort, which drops the
// block in flight and returns to IDLE.
module aes_round_ctrl #(
    parameter int unsigned RND_SIZE = 128,
    parameter int unsigned CNT_SIZE = 4,
    parameter int unsigned NUM_RND  = 10
) (
    input  logic                clk,
    input  logic                rst,
`ifdef AES_RND_CTRL_ABORT_EN
    input  logic                i_abort,
`endif
    input  logic                i_key_vld,
    input  logic                i_blk_vld,
    output logic                o_blk_rdy,
    input  logic [RND_SIZE-1:0] i_blk_text,
    output logic                o_cyp_vld,
    input  logic                i_cyp_rdy,
    output logic [RND_SIZE-1:0] o_cyp_text,
    output logic                o_rnd_en,
    output logic [CNT_SIZE-1:0] o_rnd_cnt,
    output logic [RND_SIZE-1:0] o_rnd_text,
    output logic [CNT_SIZE-1:0] o_key_idx,
    input  logic [RND_SIZE-1:0] i_rnd_key,
    output logic [RND_SIZE-1:0] o_rnd_key,
    input  logic [RND_SIZE-1:0] i_rnd_cypher,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_SIZE-1:0] RC_LAST = CNT_SIZE'(NUM_RND);
    localparam logic [CNT_SIZE-1:0] RC_ONE  = CNT_SIZE'(1);
    localparam logic [CNT_SIZE-1:0] RC_ZERO = CNT_SIZE'(0);

    state_e                state_q;
    state_e                state_d;
    logic [CNT_SIZE-1:0]   rc_q;
    logic [CNT_SIZE-1:0]   rc_d;

    logic                  abort_c;
    logic                  blk_rdy_c;
    logic                  accept_c;
    logic                  rnd_en_c;
    logic                  cyp_vld_c;
    logic [CNT_SIZE-1:0]   rnd_cnt_c;
    logic [RND_SIZE-1:0]   rnd_text_c;

    // Abort source: external pin when the feature is built in, otherwise tied off.
`ifdef AES_RND_CTRL_ABORT_EN
    assign abort_c = i_abort;
`else
    assign abort_c = 1'b0;
`endif

    // Ready only when idle or when the finished block is being drained this cycle.
    always_comb begin
        blk_rdy_c = i_key_vld & ~abort_c &
                    ((state_q == ST_IDLE) | ((state_q == ST_DONE) & i_cyp_rdy));
        accept_c  = i_blk_vld & blk_rdy_c;
    end

    // Next-state, round counter and datapath controls; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        rc_d       = rc_q;
        rnd_en_c   = 1'b0;
        cyp_vld_c  = 1'b0;
        rnd_cnt_c  = rc_q;
        rnd_text_c = i_rnd_cypher;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    rnd_en_c   = 1'b1;
                    rnd_cnt_c  = RC_ZERO;
                    rnd_text_c = i_blk_text;
                    state_d    = ST_RUN;
                    rc_d       = RC_ONE;
                end
            end
            ST_RUN: begin
                rnd_en_c = 1'b1;
                if (rc_q == RC_LAST) begin
                    state_d = ST_DONE;
                    rc_d    = RC_ZERO;
                end else begin
                    rc_d = rc_q + RC_ONE;
                end
            end
            ST_DONE: begin
                cyp_vld_c = 1'b1;
                if (i_cyp_rdy) begin
                    if (accept_c) begin
                        rnd_en_c   = 1'b1;
                        rnd_cnt_c  = RC_ZERO;
                        rnd_text_c = i_blk_text;
                        state_d    = ST_RUN;
                        rc_d       = RC_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        rc_d    = RC_ZERO;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rc_d    = RC_ZERO;
            end
        endcase

        if (abort_c && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            rc_d      = RC_ZERO;
            rnd_en_c  = 1'b0;
            cyp_vld_c = 1'b0;
        end
    end

    // State and round counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rc_q    <= RC_ZERO;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
        end
    end

    // Output wiring; the key index always tracks the round index.
    assign o_blk_rdy  = blk_rdy_c;
    assign o_rnd_en   = rnd_en_c;
    assign o_rnd_cnt  = rnd_cnt_c;
    assign o_key_idx  = rnd_cnt_c;
    assign o_rnd_text = rnd_text_c;
    assign o_rnd_key  = i_rnd_key;
    assign o_cyp_vld  = cyp_vld_c;
    assign o_cyp_text = i_rnd_cypher;
    assign o_busy     = (state_q == ST_RUN) | (state_q == ST_DONE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: emulates the round datapath and key store around the
// controller and checks ciphertext against a whole-block AES-128 reference.
module tb_aes_round_ctrl;

    logic         clk;
    logic         rst;
    logic         i_key_vld;
    logic         i_blk_vld;
    logic         o_blk_rdy;
    logic [127:0] i_blk_text;
    logic         o_cyp_vld;
    logic         i_cyp_rdy;
    logic [127:0] o_cyp_text;
    logic         o_rnd_en;
    logic [3:0]   o_rnd_cnt;
    logic [127:0] o_rnd_text;
    logic [3:0]   o_key_idx;
    logic [127:0] i_rnd_key;
    logic [127:0] o_rnd_key;
    logic [127:0] i_rnd_cypher;
    logic         o_busy;
`ifdef AES_RND_CTRL_ABORT_EN
    logic         i_abort;
`endif

    aes_round_ctrl dut (
        .clk          (clk),
        .rst          (rst),
`ifdef AES_RND_CTRL_ABORT_EN
        .i_abort      (i_abort),
`endif
        .i_key_vld    (i_key_vld),
        .i_blk_vld    (i_blk_vld),
        .o_blk_rdy    (o_blk_rdy),
        .i_blk_text   (i_blk_text),
        .o_cyp_vld    (o_cyp_vld),
        .i_cyp_rdy    (i_cyp_rdy),
        .o_cyp_text   (o_cyp_text),
        .o_rnd_en     (o_rnd_en),
        .o_rnd_cnt    (o_rnd_cnt),
        .o_rnd_text   (o_rnd_text),
        .o_key_idx    (o_key_idx),
        .i_rnd_key    (i_rnd_key),
        .o_rnd_key    (o_rnd_key),
        .i_rnd_cypher (i_rnd_cypher),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-128 helpers ----------------
    logic [7:0]   sbox [256];
    logic [127:0] ks [11];
    logic [127:0] rnd_q;
    logic [127:0] pt_a [4];
    logic [127:0] ct_a [4];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    task automatic build_sbox();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            logic [7:0] inv;
            b   = 8'(i);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, b);
            sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Round key i derived from round key i-1 (i in 1..10).
    function automatic logic [127:0] next_rk(input logic [127:0] prev, input int i);
        logic [7:0]  rc;
        logic [31:0] t;
        logic [31:0] w0, w1, w2, w3;
        rc = 8'h01;
        for (int k = 1; k < i; k++) rc = xt(rc);
        t  = subword({prev[23:0], prev[31:24]}) ^ {rc, 24'h0};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64] ^ w0;
        w2 = prev[63:32] ^ w1;
        w3 = prev[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // One AES round as a round unit would compute it (round 0 is AddRoundKey only).
    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic [3:0] r);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] res;
        if (r == 4'd0) return st ^ key;
        for (int i = 0; i < 16; i++) a[i] = sbox[st[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) b[w + 4*c] = a[w + 4*((c + w) % 4)];
        if (r != 4'd10) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] s0, s1, s2, s3;
                s0 = b[4*c]; s1 = b[4*c+1]; s2 = b[4*c+2]; s3 = b[4*c+3];
                b[4*c]   = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
                b[4*c+1] = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
                b[4*c+2] = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
                b[4*c+3] = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i];
        return res ^ key;
    endfunction

    // Whole-block reference encryption.
    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] k;
        logic [127:0] s;
        k = key;
        s = pt ^ key;
        for (int r = 1; r <= 10; r++) begin
            k = next_rk(k, r);
            s = aes_round(s, k, 4'(r));
        end
        return s;
    endfunction

    task automatic load_keys(input logic [127:0] key);
        ks[0] = key;
        for (int r = 1; r <= 10; r++) ks[r] = next_rk(ks[r-1], r);
    endtask

    // Key store (combinational lookup) and round register emulation.
    assign i_rnd_key    = (o_key_idx <= 4'd10) ? ks[o_key_idx] : 128'h0;
    assign i_rnd_cypher = rnd_q;
    always @(posedge clk) if (o_rnd_en) rnd_q <= aes_round(o_rnd_text, o_rnd_key, o_rnd_cnt);

    // ---------------- checkers ----------------
    task automatic chkb(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Runs nblk blocks (pt_a/ct_a) back to back under one key schedule.
    task automatic run_blocks(input logic [127:0] key, input int nblk, input int stall,
                              input int keywait);
        int acc;
        load_keys(key);
        @(negedge clk);
        i_cyp_rdy  = 1'b0;
        i_blk_vld  = 1'b1;
        i_blk_text = pt_a[0];
        i_key_vld  = 1'b0;
        for (int k = 0; k < keywait; k++) begin
            #1;
            chkb("keywait_rdy", o_blk_rdy, 1'b0);
            chkb("keywait_en", o_rnd_en, 1'b0);
            chkb("keywait_busy", o_busy, 1'b0);
            @(negedge clk);
        end
        i_key_vld = 1'b1;
        #1;
        chkb("acc_rdy", o_blk_rdy, 1'b1);
        chkb("acc_en", o_rnd_en, 1'b1);
        chki("acc_cnt", int'(o_rnd_cnt), 0);
        chkw("acc_text", o_rnd_text, pt_a[0]);
        acc = cyc;
        for (int b = 0; b < nblk; b++) begin
            @(negedge clk);
            for (int r = 1; r <= 10; r++) begin
                i_blk_vld  = 1'($urandom);
                i_key_vld  = 1'($urandom);
                i_cyp_rdy  = 1'($urandom);
                i_blk_text = {$urandom, $urandom, $urandom, $urandom};
                #1;
                chkb("run_en", o_rnd_en, 1'b1);
                chki("run_cnt", int'(o_rnd_cnt), r);
                chki("run_key_idx", int'(o_key_idx), r);
                chkw("run_text", o_rnd_text, rnd_q);
                chkb("run_rdy", o_blk_rdy, 1'b0);
                chkb("run_vld", o_cyp_vld, 1'b0);
                chkb("run_busy", o_busy, 1'b1);
                @(negedge clk);
            end
            i_key_vld = 1'b1;
            i_cyp_rdy = 1'b0;
            for (int s = 0; s < stall; s++) begin
                i_blk_vld = 1'($urandom);
                #1;
                chkb("stall_vld", o_cyp_vld, 1'b1);
                chkw("stall_text", o_cyp_text, ct_a[b]);
                chkb("stall_en", o_rnd_en, 1'b0);
                chkb("stall_rdy", o_blk_rdy, 1'b0);
                @(negedge clk);
            end
            i_cyp_rdy = 1'b1;
            i_blk_vld = (b < nblk - 1);
            if (b < nblk - 1) i_blk_text = pt_a[b+1];
            #1;
            chkb("done_vld", o_cyp_vld, 1'b1);
            chkw("done_text", o_cyp_text, ct_a[b]);
            chki("latency", cyc - acc, 11 + stall);
            if (b < nblk - 1) begin
                chkb("b2b_rdy", o_blk_rdy, 1'b1);
                chkb("b2b_en", o_rnd_en, 1'b1);
                chki("b2b_cnt", int'(o_rnd_cnt), 0);
                chkw("b2b_text", o_rnd_text, pt_a[b+1]);
                acc = cyc;
            end else begin
                chkb("done_en", o_rnd_en, 1'b0);
            end
        end
        @(negedge clk);
        i_cyp_rdy = 1'b0;
        i_blk_vld = 1'b0;
        #1;
        chkb("post_vld", o_cyp_vld, 1'b0);
        chkb("post_busy", o_busy, 1'b0);
        chkb("post_en", o_rnd_en, 1'b0);
    endtask

    // Accepts pt_a[0] and advances until round r is being issued.
    task automatic start_and_run_to(input logic [127:0] key, input int r);
        load_keys(key);
        @(negedge clk);
        i_key_vld  = 1'b1;
        i_cyp_rdy  = 1'b1;
        i_blk_vld  = 1'b1;
        i_blk_text = pt_a[0];
        #1;
        chkb("start_en", o_rnd_en, 1'b1);
        @(negedge clk);
        i_blk_vld = 1'b0;
        repeat (r - 1) @(negedge clk);
        #1;
        chki("start_cnt", int'(o_rnd_cnt), r);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           stall;
        int           keywait;
    } vec_t;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    vec_t tbl [8];

    initial begin
        rnd_q      = '0;
        rst        = 1'b1;
        i_key_vld  = 1'b0;
        i_blk_vld  = 1'b0;
        i_blk_text = '0;
        i_cyp_rdy  = 1'b0;
`ifdef AES_RND_CTRL_ABORT_EN
        i_abort    = 1'b0;
`endif
        build_sbox();
        load_keys(KEY_B);

        tbl[0] = '{key: KEY_B, pt: PT_B, ct: CT_B, stall: 0, keywait: 0};
        tbl[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                   pt:  128'h00112233445566778899aabbccddeeff,
                   ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a, stall: 5, keywait: 2};
        for (int i = 2; i < 8; i++) begin
            tbl[i].key     = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].pt      = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].ct      = aes_ref(tbl[i].key, tbl[i].pt);
            tbl[i].stall   = int'($urandom_range(0, 3));
            tbl[i].keywait = int'($urandom_range(0, 2));
        end

        // Reset values
        @(negedge clk);
        #1;
        chkb("rst_en", o_rnd_en, 1'b0);
        chkb("rst_vld", o_cyp_vld, 1'b0);
        chkb("rst_busy", o_busy, 1'b0);
        chki("rst_cnt", int'(o_rnd_cnt), 0);
        chki("rst_key_idx", int'(o_key_idx), 0);
        chkb("rst_rdy_lo", o_blk_rdy, 1'b0);
        i_key_vld = 1'b1;
        #1;
        chkb("rst_rdy_hi", o_blk_rdy, 1'b1);
        @(negedge clk);
        rst       = 1'b0;
        i_key_vld = 1'b0;

        // Table-driven single blocks
        for (int i = 0; i < 8; i++) begin
            pt_a[0] = tbl[i].pt;
            ct_a[0] = tbl[i].ct;
            run_blocks(tbl[i].key, 1, tbl[i].stall, tbl[i].keywait);
        end

        // Two blocks back to back, sink always ready
        pt_a[0] = PT_B;
        ct_a[0] = CT_B;
        pt_a[1] = {$urandom, $urandom, $urandom, $urandom};
        ct_a[1] = aes_ref(KEY_B, pt_a[1]);
        run_blocks(KEY_B, 2, 0, 0);

        // Three random blocks chained through a stalled sink
        begin
            logic [127:0] k;
            k = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 3; i++) begin
                pt_a[i] = {$urandom, $urandom, $urandom, $urandom};
                ct_a[i] = aes_ref(k, pt_a[i]);
            end
            run_blocks(k, 3, int'($urandom_range(1, 3)), 0);
        end

        // Reset in the middle of round 5
        pt_a[0] = {$urandom, $urandom, $urandom, $urandom};
        start_and_run_to(KEY_B, 5);
        rst = 1'b1;
        #1;
        chkb("mrst_en", o_rnd_en, 1'b0);
        chkb("mrst_vld", o_cyp_vld, 1'b0);
        chkb("mrst_busy", o_busy, 1'b0);
        chki("mrst_cnt", int'(o_rnd_cnt), 0);
        chki("mrst_key_idx", int'(o_key_idx), 0);
        chkb("mrst_rdy", o_blk_rdy, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chkb("mrst_no_out", o_cyp_vld, 1'b0);
            @(negedge clk);
        end
        pt_a[0] = PT_B;
        ct_a[0] = CT_B;
        run_blocks(KEY_B, 1, 0, 0);

`ifdef AES_RND_CTRL_ABORT_EN
        // Abort at round 4, then abort while idle, then a clean block
        pt_a[0] = {$urandom, $urandom, $urandom, $urandom};
        start_and_run_to(KEY_B, 4);
        i_abort = 1'b1;
        #1;
        chkb("abort_en", o_rnd_en, 1'b0);
        chkb("abort_vld", o_cyp_vld, 1'b0);
        @(negedge clk);
        i_abort   = 1'b1;
        i_blk_vld = 1'b1;
        #1;
        chkb("abort_idle_busy", o_busy, 1'b0);
        chki("abort_idle_cnt", int'(o_rnd_cnt), 0);
        chkb("abort_idle_rdy", o_blk_rdy, 1'b0);
        chkb("abort_idle_en", o_rnd_en, 1'b0);
        @(negedge clk);
        i_abort   = 1'b0;
        i_blk_vld = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chkb("abort_no_out", o_cyp_vld, 1'b0);
            chkb("abort_no_busy", o_busy, 1'b0);
            @(negedge clk);
        end
        pt_a[0] = PT_B;
        ct_a[0] = CT_B;
        run_blocks(KEY_B, 1, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
